demux_1to8_stream: RTL

DEMUX_1TO8_STREAM -- requirements
Module: demux_1to8_stream

---
 rtl/demux_1to8_stream.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux_1to8_stream.sv
// 1-to-8 stream demultiplexer with a one-beat register per output channel.
// Beats are steered by in_sel; each channel pops independently of the rest.
module demux_1to8_stream #(
  parameter int width  = 4,
  parameter int swidth = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [width-1:0]  in_data,
  input  logic [swidth-1:0] in_sel,
  output logic              in_ready,
  output logic [width-1:0]  o0,
  output logic [width-1:0]  o1,
  output logic [width-1:0]  o2,
  output logic [width-1:0]  o3,
  output logic [width-1:0]  o4,
  output logic [width-1:0]  o5,
  output logic [width-1:0]  o6,
  output logic [width-1:0]  o7,
  output logic [7:0]        o_valid,
  input  logic [7:0]        o_ready,
  output logic [7:0]        xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        st_q   [8];
  logic [width-1:0] data_q [8];
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       load;
  logic [7:0]       pop;
  logic             accept;

  // A full slot may take a new beat only if it drains on the same edge.
  always_comb begin
    in_ready = rst_n & (~o_valid[in_sel] | o_ready[in_sel]);
  end

  assign accept = in_valid & in_ready;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    assign o_valid[k] = (st_q[k] == FULL);
    assign pop[k]     = o_valid[k] & o_ready[k];
    assign load[k]    = accept & (in_sel == swidth'(k));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q[k]   <= EMPTY;
        data_q[k] <= '0;
      end else begin
        unique case (st_q[k])
          EMPTY: begin
            if (load[k]) begin
              st_q[k]   <= FULL;
              data_q[k] <= in_data;
            end
          end
          FULL: begin
            if (load[k]) begin
              data_q[k] <= in_data;
            end else if (pop[k]) begin
              st_q[k] <= EMPTY;
            end
          end
          default: st_q[k] <= EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
  assign o0 = data_q[0];
  assign o1 = data_q[1];
  assign o2 = data_q[2];
  assign o3 = data_q[3];
  assign o4 = data_q[4];
  assign o5 = data_q[5];
  assign o6 = data_q[6];
  assign o7 = data_q[7];

endmodule
